// File: rtl/vpi_counter_ctrl_pkg.sv
// Shared types and constants for the counter-bank sequencing controller.
//   cmd_op_e : command opcodes carried on cmd_op
//   state_e  : controller FSM states (IDLE / RUN / DONE)
//   LANE*_W  : widths of the four counter lanes
package vpi_counter_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_START = 2'd1,
        OP_STOP  = 2'd2,
        OP_CLEAR = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int LANE0_W = 1;
    localparam int LANE1_W = 8;
    localparam int LANE2_W = 32;
    localparam int LANE3_W = 64;

endpackage

// File: rtl/vpi_counter_lane.sv
// One counter lane: a base register and a counter that steps by (1 + base)
// modulo 2^W whenever inc is asserted.
// Optional feature macro: CNT_WRAP_EN adds a sticky wrap flag.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   base_we     load base from base_in
//   base_in     new base value (already truncated to W bits)
//   inc         step the counter this edge
//   clr         zero the counter (and wrap flag); base is kept
//   value       registered counter value
//   wrap        (CNT_WRAP_EN only) sticky flag, set when a step lands below the old value
module vpi_counter_lane #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         base_we,
    input  logic [W-1:0] base_in,
    input  logic         inc,
    input  logic         clr,
`ifdef CNT_WRAP_EN
    output logic         wrap,
`endif
    output logic [W-1:0] value
);

    logic [W-1:0] base_q;
    logic [W-1:0] next_value;

    // Plain W-bit addition gives the silent modular wrap.
    assign next_value = value + W'(1) + base_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
        end else if (base_we) begin
            base_q <= base_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= next_value;
        end
    end

`ifdef CNT_WRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap <= 1'b0;
        end else if (clr) begin
            wrap <= 1'b0;
        end else if (inc && (next_value < value)) begin
            wrap <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/vpi_counter_ctrl.sv
// Sequencing controller for four counter lanes (1/8/32/64 bit).
// Loads per-lane bases over a cfg handshake and runs the bank for a commanded
// number of cycles.
// Optional feature macro: CNT_WRAP_EN adds output wrap[3:0] (sticky per lane).
// Handshakes: a transfer happens on a posedge where valid and ready are both
//   high; ready depends only on FSM state and, in RUN, on cmd_op.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cfg_valid/cfg_ready   base-write handshake; cfg_sel picks lane, cfg_data value
//   cmd_valid/cmd_ready   command handshake; cmd_op opcode, cmd_len run length
//   v1..v4                lane counter values
//   remain                cycles left in the current run
//   busy                  high while running
//   done                  one-cycle pulse when a run ends
module vpi_counter_ctrl
    import vpi_counter_ctrl_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [1:0]           cfg_sel,
    input  logic [63:0]          cfg_data,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [LEN_W-1:0]     cmd_len,
    output logic [LANE0_W-1:0]   v1,
    output logic [LANE1_W-1:0]   v2,
    output logic [LANE2_W-1:0]   v3,
    output logic [LANE3_W-1:0]   v4,
`ifdef CNT_WRAP_EN
    output logic [3:0]           wrap,
`endif
    output logic [LEN_W-1:0]     remain,
    output logic                 busy,
    output logic                 done
);

    state_e           state, state_d;
    logic [LEN_W-1:0] remain_d;
    logic             inc, clr;
    logic             cmd_fire, cfg_fire;
    logic [3:0]       base_we;
    cmd_op_e          op;

    assign op       = cmd_op_e'(cmd_op);
    assign cmd_fire = cmd_valid && cmd_ready;
    assign cfg_fire = cfg_valid && cfg_ready;

    always_comb begin
        base_we = 4'b0000;
        if (cfg_fire) begin
            base_we[cfg_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            remain <= '0;
        end else begin
            state  <= state_d;
            remain <= remain_d;
        end
    end

    always_comb begin
        state_d   = state;
        remain_d  = remain;
        inc       = 1'b0;
        clr       = 1'b0;
        cfg_ready = 1'b0;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                cmd_ready = 1'b1;
                if (cmd_fire) begin
                    case (op)
                        OP_START: begin
                            // A zero-length run ends immediately with no steps.
                            if (cmd_len == '0) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d  = ST_RUN;
                                remain_d = cmd_len;
                            end
                        end
                        OP_CLEAR: clr = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                busy      = 1'b1;
                cmd_ready = (op == OP_STOP);
                if (cmd_fire) begin
                    // STOP wins over the step: counters and remain hold.
                    state_d = ST_DONE;
                end else begin
                    inc      = 1'b1;
                    remain_d = remain - LEN_W'(1);
                    if (remain == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    vpi_counter_lane #(.W(LANE0_W)) u_lane0 (
        .clk(clk), .rst(rst), .base_we(base_we[0]), .base_in(cfg_data[LANE0_W-1:0]),
        .inc(inc), .clr(clr),
`ifdef CNT_WRAP_EN
        .wrap(wrap[0]),
`endif
        .value(v1)
    );

    vpi_counter_lane #(.W(LANE1_W)) u_lane1 (
        .clk(clk), .rst(rst), .base_we(base_we[1]), .base_in(cfg_data[LANE1_W-1:0]),
        .inc(inc), .clr(clr),
`ifdef CNT_WRAP_EN
        .wrap(wrap[1]),
`endif
        .value(v2)
    );

    vpi_counter_lane #(.W(LANE2_W)) u_lane2 (
        .clk(clk), .rst(rst), .base_we(base_we[2]), .base_in(cfg_data[LANE2_W-1:0]),
        .inc(inc), .clr(clr),
`ifdef CNT_WRAP_EN
        .wrap(wrap[2]),
`endif
        .value(v3)
    );

    vpi_counter_lane #(.W(LANE3_W)) u_lane3 (
        .clk(clk), .rst(rst), .base_we(base_we[3]), .base_in(cfg_data[LANE3_W-1:0]),
        .inc(inc), .clr(clr),
`ifdef CNT_WRAP_EN
        .wrap(wrap[3]),
`endif
        .value(v4)
    );

endmodule

// File: tb/tb_vpi_counter_ctrl.sv
// Directed bench for vpi_counter_ctrl with a lane model and expected-value queue.
module tb_vpi_counter_ctrl;
    import vpi_counter_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid, cfg_ready, cmd_valid, cmd_ready;
    logic [1:0]  cfg_sel, cmd_op;
    logic [63:0] cfg_data;
    logic [15:0] cmd_len, remain;
    logic [0:0]  v1;
    logic [7:0]  v2;
    logic [31:0] v3;
    logic [63:0] v4;
    logic        busy, done;
`ifdef CNT_WRAP_EN
    logic [3:0]  wrap;
`endif

    always #5 clk = ~clk;

    vpi_counter_ctrl #(.LEN_W(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .v1(v1), .v2(v2), .v3(v3), .v4(v4),
`ifdef CNT_WRAP_EN
        .wrap(wrap),
`endif
        .remain(remain), .busy(busy), .done(done)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] m_val[4];
    logic [63:0] m_base[4];

    function automatic logic [63:0] lane_mask(input int k);
        case (k)
            0:       return 64'h1;
            1:       return 64'hFF;
            2:       return 64'hFFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_val[k]  = '0;
            m_base[k] = '0;
        end
        exp_q.delete();
    endtask

    // Advance the model by n steps and queue the resulting lane values.
    task automatic model_run(input int n);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < n; i++) begin
                m_val[k] = (m_val[k] + 64'd1 + m_base[k]) & lane_mask(k);
            end
            exp_q.push_back(m_val[k]);
        end
    endtask

    task automatic check_lanes(input string tag);
        logic [63:0] e;
        if (exp_q.size() < 4) begin
            check({tag, "_queue"}, 64'(exp_q.size()), 64'd4);
        end else begin
            e = exp_q.pop_front(); check({tag, "_v1"}, {63'd0, v1}, e);
            e = exp_q.pop_front(); check({tag, "_v2"}, {56'd0, v2}, e);
            e = exp_q.pop_front(); check({tag, "_v3"}, {32'd0, v3}, e);
            e = exp_q.pop_front(); check({tag, "_v4"}, v4, e);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic cmd_en, input logic [1:0] op, input logic [15:0] len,
                         input logic cfg_en, input logic [1:0] sel, input logic [63:0] data);
        @(negedge clk);
        cmd_valid = cmd_en; cmd_op = op; cmd_len = len;
        cfg_valid = cfg_en; cfg_sel = sel; cfg_data = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cfg_valid = 1'b0;
        if (cfg_en) m_base[sel] = data & lane_mask(int'(sel));
        if (cmd_en && op == 2'(OP_CLEAR)) begin
            for (int k = 0; k < 4; k++) m_val[k] = '0;
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [15:0] len);
        drive(1'b1, op, len, 1'b0, 2'd0, 64'd0);
    endtask

    task automatic do_cfg(input logic [1:0] sel, input logic [63:0] data);
        drive(1'b0, 2'd0, 16'd0, 1'b1, sel, data);
    endtask

    // Count busy cycles until the done pulse, then require done to drop.
    task automatic wait_done(input string tag, input int exp_busy);
        int n = 0;
        int guard = 0;
        @(negedge clk);
        while (!done && guard < 500) begin
            if (busy) n++;
            guard++;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, {63'd0, done}, 64'd1);
        check({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int guard;
        rst = 1'b1;
        cfg_valid = 1'b0; cfg_sel = '0; cfg_data = '0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: reset state, idle cycles
        check("rst_v1", {63'd0, v1}, 64'd0);
        check("rst_v2", {56'd0, v2}, 64'd0);
        check("rst_v3", {32'd0, v3}, 64'd0);
        check("rst_v4", v4, 64'd0);
        check("rst_remain", {48'd0, remain}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
`ifdef CNT_WRAP_EN
        check("rst_wrap", {60'd0, wrap}, 64'd0);
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_done", {63'd0, done}, 64'd0);
            check("idle_cfg_ready", {63'd0, cfg_ready}, 64'd1);
        end

        // 2: START len=10 with zero bases
        do_cmd(2'(OP_START), 16'd10);
        model_run(10);
        wait_done("t2", 10);
        check_lanes("t2");

        // 3: bases then START len=4 from cleared counters
        do_cmd(2'(OP_CLEAR), 16'd0);
        do_cfg(2'd1, 64'd3);
        do_cfg(2'd3, 64'hFFFF_FFFF_FFFF_FFFE);
        do_cmd(2'(OP_START), 16'd4);
        model_run(4);
        wait_done("t3", 4);
        check_lanes("t3");
`ifdef CNT_WRAP_EN
        check("t3_wrap3", {63'd0, wrap[3]}, 64'd1);
        check("t3_wrap1", {63'd0, wrap[1]}, 64'd0);
`endif

        // 4: START len=100, STOP after 7 steps
        do_cmd(2'(OP_CLEAR), 16'd0);
        do_cmd(2'(OP_START), 16'd100);
        check("t4_cfg_ready_run", {63'd0, cfg_ready}, 64'd0);
        repeat (7) @(posedge clk);
        do_cmd(2'(OP_STOP), 16'd0);
        model_run(7);
        @(negedge clk);
        check("t4_done", {63'd0, done}, 64'd1);
        check("t4_cfg_ready_done", {63'd0, cfg_ready}, 64'd0);
        check("t4_cmd_ready_done", {63'd0, cmd_ready}, 64'd0);
        check("t4_remain", {48'd0, remain}, 64'd93);
        @(negedge clk);
        check("t4_done_drop", {63'd0, done}, 64'd0);
        check_lanes("t4");

        // 5: zero-length START, then CLEAR keeps bases
        do_cmd(2'(OP_START), 16'd0);
        model_run(0);
        wait_done("t5_len0", 0);
        check_lanes("t5_len0");
        do_cmd(2'(OP_CLEAR), 16'd0);
        do_cmd(2'(OP_START), 16'd1);
        model_run(1);
        wait_done("t5_len1", 1);
        check_lanes("t5_len1");

        // cfg accepted on the same edge as START feeds the first step
        drive(1'b1, 2'(OP_START), 16'd2, 1'b1, 2'd2, 64'd5);
        model_run(2);
        wait_done("t5_same_edge", 2);
        check_lanes("t5_same_edge");

        // 6: asynchronous reset mid-run
        do_cmd(2'(OP_START), 16'd60);
        guard = 0;
        while (remain != 16'd50 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("t6_reach_remain50", {48'd0, remain}, 64'd50);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("t6_async_v2", {56'd0, v2}, 64'd0);
        check("t6_async_v4", v4, 64'd0);
        check("t6_async_remain", {48'd0, remain}, 64'd0);
        check("t6_async_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("t6_no_done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        do_cmd(2'(OP_START), 16'd5);
        model_run(5);
        wait_done("t6_after", 5);
        check_lanes("t6_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
